// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
// Holds the sample widths, the real/imag slice positions inside a packed
// {real, imag} word, the complex sample type, and the halved add/subtract
// helpers used by every butterfly stage.
package fft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CPLX_W   = 32;

  // Slice positions of the components inside a CPLX_W word.
  localparam int RE_HI = 31;
  localparam int RE_LO = 16;
  localparam int IM_HI = 15;
  localparam int IM_LO = 0;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;

  // (a + b) >>> 1 with a 17-bit sign-extended intermediate. Taking bits
  // [16:1] is the arithmetic shift, so the result rounds toward -inf and
  // always fits back into 16 bits.
  function automatic logic [SAMPLE_W-1:0] halfadd(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    return s[SAMPLE_W:1];
  endfunction

  // (a - b) >>> 1, same width handling as halfadd.
  function automatic logic [SAMPLE_W-1:0] halfsub(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
    return s[SAMPLE_W:1];
  endfunction

endpackage

// File: rtl/sdf_r2_butterfly_stage_if.sv
// Stream interface of one SDF radix-2 butterfly stage.
// Handshake: there is no ready. The stage accepts one sample on every cycle
// where IN_VALID is high (or advances on FLUSH with a zero sample), and
// OUT_VALID is a single-cycle qualifier for OUT_R32/OUT_TWIDX/OUT_TWACT that
// the consumer must take when it is high; there is no backpressure.
//   IN_VALID, FLUSH, IN_A32            : producer -> stage
//   OUT_VALID, OUT_R32, OUT_TWIDX,
//   OUT_TWACT                          : stage -> twiddle multiplier
//   dbg_cnt, dbg_primed                : stage internal state, observation only
interface sdf_r2_butterfly_stage_if
  import fft_pkg::*;
#(
  parameter int LOG2_DEPTH = 5
);
  logic                  IN_VALID;
  logic                  FLUSH;
  logic [CPLX_W-1:0]     IN_A32;
  logic                  OUT_VALID;
  logic [CPLX_W-1:0]     OUT_R32;
  logic [LOG2_DEPTH-1:0] OUT_TWIDX;
  logic                  OUT_TWACT;
  logic [LOG2_DEPTH:0]   dbg_cnt;
  logic                  dbg_primed;

  modport slave (
    input  IN_VALID, FLUSH, IN_A32,
    output OUT_VALID, OUT_R32, OUT_TWIDX, OUT_TWACT, dbg_cnt, dbg_primed
  );

  modport master (
    output IN_VALID, FLUSH, IN_A32,
    input  OUT_VALID, OUT_R32, OUT_TWIDX, OUT_TWACT, dbg_cnt, dbg_primed
  );
endinterface

// File: rtl/sdf_delay_line.sv
// Enable-gated feedback delay line of an SDF stage.
//   CLK, RST : clock, asynchronous active-high clear of every entry
//   en       : shift one position (frozen when low)
//   din      : value entering the line
//   head     : oldest entry, DEPTH shifts after it was written
module sdf_delay_line #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign head = taps[DEPTH-1];

endmodule

// File: rtl/sdf_r2_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// The first DEPTH samples of a block are parked in the delay line while the
// previous block's differences drain out; the second DEPTH samples meet
// their partners at the head, the halved sums go out immediately and the
// halved differences are pushed back for the next fill phase.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of sdf_r2_butterfly_stage_if (sample stream in,
//              butterfly result + twiddle index out, debug state)
module sdf_r2_butterfly_stage
  import fft_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int LOG2_DEPTH = 5
) (
  input logic                     CLK,
  input logic                     RST,
  sdf_r2_butterfly_stage_if.slave bus
);

  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      cnt;
  logic                  primed;
  logic                  adv;
  logic                  phase;
  logic [LOG2_DEPTH-1:0] k;
  cplx_t                 din;
  cplx_t                 head;
  cplx_t                 sum_c;
  cplx_t                 diff_c;
  cplx_t                 push;
  cplx_t                 cand;

  logic                  out_valid_q;
  logic [CPLX_W-1:0]     out_r_q;
  logic [LOG2_DEPTH-1:0] out_twidx_q;
  logic                  out_twact_q;

  assign adv = bus.IN_VALID | bus.FLUSH;

  // Phase compare instead of the counter MSB so DEPTH=1 (cnt wraps at 1)
  // still splits into one fill and one butterfly slot.
  assign phase = (cnt >= CNT_DEPTH);
  assign k     = cnt[LOG2_DEPTH-1:0];

  always_comb begin
    din = '0;
    if (bus.IN_VALID) begin
      din.re = bus.IN_A32[RE_HI:RE_LO];
      din.im = bus.IN_A32[IM_HI:IM_LO];
    end
  end

  always_comb begin
    sum_c.re  = halfadd(head.re, din.re);
    sum_c.im  = halfadd(head.im, din.im);
    diff_c.re = halfsub(head.re, din.re);
    diff_c.im = halfsub(head.im, din.im);
    push      = phase ? diff_c : din;
    cand      = phase ? sum_c  : head;
  end

  sdf_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (CPLX_W)
  ) u_delay (
    .CLK  (CLK),
    .RST  (RST),
    .en   (adv),
    .din  (push),
    .head (head)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= '0;
      primed      <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_twidx_q <= '0;
      out_twact_q <= 1'b0;
    end else if (adv) begin
      cnt         <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      // Fill-phase outputs of the very first block carry reset zeros, not
      // real differences, so they stay invalid until a butterfly phase ran.
      out_valid_q <= phase | primed;
      out_r_q     <= cand;
      out_twidx_q <= phase ? '0 : k;
      out_twact_q <= phase ? 1'b0 : primed;
      if (phase) primed <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_R32    = out_r_q;
  assign bus.OUT_TWIDX  = out_twidx_q;
  assign bus.OUT_TWACT  = out_twact_q;
  assign bus.dbg_cnt    = cnt;
  assign bus.dbg_primed = primed;

endmodule

// File: tb/tb_sdf_r2_butterfly_stage.sv
// Testbench for sdf_r2_butterfly_stage at DEPTH=4.
module tb_sdf_r2_butterfly_stage;

  localparam int D  = 4;
  localparam int LD = 2;
  localparam int W  = 32 + LD + 1;   // {r32, twidx, twact}

  localparam logic [1:0] OP_IN    = 2'd0;
  localparam logic [1:0] OP_FLUSH = 2'd1;
  localparam logic [1:0] OP_RST   = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  typedef struct {
    logic [1:0]    op;
    logic [31:0]   din;
    bit            exp_v;
    logic [31:0]   exp_r;
    logic [LD-1:0] exp_idx;
    bit            exp_act;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdf_r2_butterfly_stage_if #(.LOG2_DEPTH(LD)) bus ();

  sdf_r2_butterfly_stage #(
    .DEPTH      (D),
    .LOG2_DEPTH (LD)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cap_q[$];
  logic [W-1:0] run_a[$];
  int n_chk;
  int n_pass;
  int vld_cnt;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  // Block-oriented: first-half samples and pending differences are kept in
  // arrays indexed by the position inside the half block.
  logic [31:0] m_first[D];
  logic [31:0] m_diff[D];
  int          m_k;
  bit          m_primed;

  function automatic logic [15:0] half(input logic [15:0] a, input logic [15:0] b,
                                       input bit sub);
    logic signed [31:0] r;
    r = sub ? (32'($signed(a)) - 32'($signed(b))) : (32'($signed(a)) + 32'($signed(b)));
    r = r >>> 1;
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_first[i] = '0;
      m_diff[i]  = '0;
    end
    m_k = 0;
    m_primed = 0;
  endtask

  task automatic model_step(input logic [31:0] x, input bit pm);
    int j;
    logic [31:0] s;
    logic [31:0] df;
    if (m_k < D) begin
      if (m_primed && pm) exp_q.push_back({m_diff[m_k], LD'(m_k), 1'b1});
      m_first[m_k] = x;
    end else begin
      j  = m_k - D;
      s  = {half(m_first[j][31:16], x[31:16], 0), half(m_first[j][15:0], x[15:0], 0)};
      df = {half(m_first[j][31:16], x[31:16], 1), half(m_first[j][15:0], x[15:0], 1)};
      m_diff[j] = df;
      if (pm) exp_q.push_back({s, LD'(0), 1'b0});
      m_primed = 1;
    end
    m_k = (m_k + 1) % (2 * D);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; any expectation is queued at the same
  // moment so it is popped right after the next rising edge.
  task automatic drive(input bit v, input bit f, input logic [31:0] d, input bit pm,
                       input bit has_tbl, input logic [W-1:0] tbl_exp);
    @(negedge clk);
    bus.IN_VALID = v;
    bus.FLUSH    = f;
    bus.IN_A32   = d;
    if (has_tbl) exp_q.push_back(tbl_exp);
    if (v | f) model_step(v ? d : 32'h0, pm);
  endtask

  task automatic idle();
    drive(0, 0, $urandom, 0, 0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.IN_VALID = 0;
    bus.FLUSH    = 0;
    rst = 1;
    #1;
    check("rst_out_valid", {63'd0, bus.OUT_VALID}, 64'd0);
    check("rst_out_r32",   {32'd0, bus.OUT_R32},   64'd0);
    check("rst_out_twidx", {62'd0, bus.OUT_TWIDX}, 64'd0);
    check("rst_out_twact", {63'd0, bus.OUT_TWACT}, 64'd0);
    check("rst_cnt",       {61'd0, bus.dbg_cnt},   64'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    #1;
    if (!rst) begin
      if (bus.OUT_VALID) begin
        vld_cnt++;
        got = {bus.OUT_R32, bus.OUT_TWIDX, bus.OUT_TWACT};
        cap_q.push_back(got);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: OUT_VALID got 1 required 0 (out %h, t=%0t)", got, $time);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", {29'd0, got}, {29'd0, e});
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk++;
        $display("FAIL missing_output: OUT_VALID got 0 required 1 (expected %h, t=%0t)", e, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time got %0t required < 500000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  vec_t tbl[27];

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] din, input bit ev,
                              input logic [31:0] er, input logic [LD-1:0] ei, input bit ea);
    vec_t v;
    v.op = op; v.din = din; v.exp_v = ev; v.exp_r = er; v.exp_idx = ei; v.exp_act = ea;
    return v;
  endfunction

  initial begin
    logic [31:0] smp[8];
    int vld0;
    int r;
    logic [31:0] d;

    n_chk = 0; n_pass = 0; vld_cnt = 0;
    rst = 1;
    bus.IN_VALID = 0; bus.FLUSH = 0; bus.IN_A32 = '0;

    // Sums, then differences drained by FLUSH.
    for (int i = 0; i < 4; i++) tbl[i] = mk(OP_IN, {16'(16 * (i + 1)), 16'h0}, 0, '0, 0, 0);
    for (int i = 4; i < 8; i++)
      tbl[i] = mk(OP_IN, {16'(16 * (i + 1)), 16'h0}, 1, {16'(16 * (i - 1)), 16'h0}, 0, 0);
    for (int i = 8; i < 12; i++) tbl[i] = mk(OP_FLUSH, '0, 1, 32'hFFE0_0000, LD'(i - 8), 1);
    // Butterfly against the zeros the flush left behind, then reset mid-stream.
    tbl[12] = mk(OP_IDLE, 32'hDEAD_BEEF, 0, '0, 0, 0);
    tbl[13] = mk(OP_IN, 32'h0010_0000, 1, 32'h0008_0000, 0, 0);
    tbl[14] = mk(OP_RST, '0, 0, '0, 0, 0);
    // Extremes and rounding toward -inf; the first block after reset is quiet.
    tbl[15] = mk(OP_IN, 32'h8000_7FFF, 0, '0, 0, 0);
    for (int i = 16; i < 19; i++) tbl[i] = mk(OP_IN, 32'h0003_FFFC, 0, '0, 0, 0);
    tbl[19] = mk(OP_IN, 32'h7FFF_7FFF, 1, 32'hFFFF_7FFF, 0, 0);
    for (int i = 20; i < 23; i++) tbl[i] = mk(OP_IN, 32'hFFFF_FFFF, 1, 32'h0001_FFFD, 0, 0);
    tbl[23] = mk(OP_FLUSH, '0, 1, 32'h8000_0000, 0, 1);
    for (int i = 24; i < 27; i++) tbl[i] = mk(OP_FLUSH, '0, 1, 32'h0002_FFFE, LD'(i - 23), 1);

    apply_reset();

    for (int i = 0; i < 27; i++) begin
      case (tbl[i].op)
        OP_RST:  apply_reset();
        OP_IDLE: idle();
        default: drive(tbl[i].op == OP_IN, tbl[i].op == OP_FLUSH, tbl[i].din, 0,
                       tbl[i].exp_v, {tbl[i].exp_r, tbl[i].exp_idx, tbl[i].exp_act});
      endcase
    end
    idle();

    // Stall: same samples gapless, then with a 3-cycle gap mid-butterfly.
    for (int i = 0; i < 8; i++) smp[i] = $urandom;
    apply_reset();
    cap_q.delete();
    for (int i = 0; i < 8; i++) drive(1, 0, smp[i], 1, 0, '0);
    for (int i = 0; i < 4; i++) drive(0, 1, $urandom, 1, 0, '0);
    idle();
    run_a = cap_q;
    check("gapless_len", 64'(run_a.size()), 64'd8);

    apply_reset();
    cap_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) for (int g = 0; g < 3; g++) idle();
      drive(1, 0, smp[i], 1, 0, '0);
    end
    for (int i = 0; i < 4; i++) drive(0, 1, $urandom, 1, 0, '0);
    idle();
    check("stall_len", 64'(cap_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < cap_q.size() && i < run_a.size())
        check("stall_vs_gapless", {29'd0, cap_q[i]}, {29'd0, run_a[i]});

    // Back-to-back frames: after the first fill, every sample yields an output.
    apply_reset();
    vld0 = vld_cnt;
    for (int i = 0; i < 24; i++) drive(1, 0, $urandom, 1, 0, '0);
    idle();
    check("b2b_valid_count", 64'(vld_cnt - vld0), 64'd20);

    // Random mix of samples, flushes (with and without IN_VALID) and idles.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      d = ($urandom_range(0, 7) == 0) ? 32'h8000_7FFF : $urandom;
      if (r <= 5)      drive(1, 0, d, 1, 0, '0);
      else if (r <= 7) drive(0, 1, d, 1, 0, '0);
      else if (r == 8) drive(1, 1, d, 1, 0, '0);
      else             idle();
    end
    idle();
    idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
